// File: rtl/gc_collector_pkg.sv
// rtl/gc_collector_pkg.sv - shared types, tag codes and tag decoder for the garbler output collector
//
// Purpose : record type enum, garbler tag encodings and a decoder that maps a
//           garbler tag onto slot-valid bits, record type and index source.
// Contents: rec_type_e, TAG_* constants, idx_src_e, tag_dec_t, decode_tag().
package gc_collector_pkg;

  typedef enum logic [1:0] {
    REC_LABEL = 2'd0,
    REC_KEY   = 2'd1,
    REC_TABLE = 2'd2,
    REC_MASK  = 2'd3
  } rec_type_e;

  localparam logic [2:0] TAG_KEY   = 3'b001;
  localparam logic [2:0] TAG_TABLE = 3'b010;
  localparam logic [2:0] TAG_MASK  = 3'b011;
  localparam int         TAG_LABEL_BIT = 2;

  // Where a record's index comes from: the garbler index inputs, the slot
  // number itself (keys are numbered 0/1), or constant zero (mask).
  typedef enum logic [1:0] {
    IDX_TAG  = 2'd0,
    IDX_SLOT = 2'd1,
    IDX_ZERO = 2'd2
  } idx_src_e;

  typedef struct packed {
    logic      v0;
    logic      v1;
    rec_type_e rtype;
    idx_src_e  idx_src;
  } tag_dec_t;

  // An idle tag decodes to v0 = v1 = 0; callers treat that as "nothing to push".
  function automatic tag_dec_t decode_tag(input logic [2:0] tag);
    tag_dec_t d;
    d.v0      = 1'b0;
    d.v1      = 1'b0;
    d.rtype   = REC_LABEL;
    d.idx_src = IDX_TAG;
    if (tag[TAG_LABEL_BIT]) begin
      d.v0 = tag[0];
      d.v1 = tag[1];
    end else begin
      case (tag)
        TAG_KEY: begin
          d.v0      = 1'b1;
          d.v1      = 1'b1;
          d.rtype   = REC_KEY;
          d.idx_src = IDX_SLOT;
        end
        TAG_TABLE: begin
          d.v0      = 1'b1;
          d.v1      = 1'b1;
          d.rtype   = REC_TABLE;
        end
        TAG_MASK: begin
          d.v0      = 1'b1;
          d.rtype   = REC_MASK;
          d.idx_src = IDX_ZERO;
        end
        default: ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/gc_pair_fifo.sv
// rtl/gc_pair_fifo.sv - single-clock FWFT FIFO holding one record pair per entry
//
// Purpose : 1-write/1-read synchronous FIFO; the head entry is read straight
//           from registered storage so a push is visible the following cycle.
// Ports   : clk, rst (async, active-low)
//           i_push/i_data   write request and entry
//           i_pop           read request (ignored when empty)
//           o_head          head entry (don't-care when empty)
//           o_full/o_empty/o_count  occupancy
module gc_pair_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  output T                         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gc_output_collector.sv
// rtl/gc_output_collector.sv - collects the garbler result stream into a typed record stream
//
// Purpose : decodes each garbler cycle into up to two records, buffers them
//           one cycle per FIFO entry and drains one record per handshake.
//           The garbler cannot stall, so a push into a full FIFO is dropped
//           and flagged on the sticky overflow output.
// Ports   : clk, rst (async, active-low)
//           tag_t1, cid, index0_t1, index1_t1, data0_t1, data1_t1  garbler stream
//           out_valid/out_ready  record handshake
//           out_type, out_cid, out_index, out_data, out_last  record fields
//           overflow  sticky drop flag
//           done      end-of-run cycle seen and every record drained
module gc_output_collector
  import gc_collector_pkg::*;
#(
  parameter int S     = 10,
  parameter int K     = 128,
  parameter int CC    = 1,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   tag_t1,
  input  logic [S-1:0] cid,
  input  logic [S-1:0] index0_t1,
  input  logic [S-1:0] index1_t1,
  input  logic [K-1:0] data0_t1,
  input  logic [K-1:0] data1_t1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_type,
  output logic [S-1:0] out_cid,
  output logic [S-1:0] out_index,
  output logic [K-1:0] out_data,
  output logic         out_last,
  output logic         overflow,
  output logic         done
);

  localparam int             CW    = $clog2(DEPTH) + 1;
  localparam logic [S-1:0]   CC_ID = S'(CC);

  typedef struct packed {
    logic          v0;
    logic          v1;
    rec_type_e     rtype;
    logic [S-1:0]  cid;
    logic [S-1:0]  idx0;
    logic [S-1:0]  idx1;
    logic [K-1:0]  data0;
    logic [K-1:0]  data1;
  } rec_pair_t;

  tag_dec_t        w_dec;
  rec_pair_t       w_new;
  rec_pair_t       w_head;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic            w_valid;
  logic            w_sel1;
  logic            w_cur_last;
  logic            w_xfer;

  logic            r_sub;
  logic            r_cc_seen;
  logic            r_overflow;
  logic            r_done;

  assign w_dec      = decode_tag(tag_t1);
  assign w_push_req = (cid != CC_ID) && (w_dec.v0 || w_dec.v1);

  always_comb begin
    w_new       = '0;
    w_new.v0    = w_dec.v0;
    w_new.v1    = w_dec.v1;
    w_new.rtype = w_dec.rtype;
    w_new.cid   = cid;
    w_new.data0 = data0_t1;
    w_new.data1 = data1_t1;
    case (w_dec.idx_src)
      IDX_SLOT: begin
        w_new.idx0 = '0;
        w_new.idx1 = S'(1);
      end
      IDX_ZERO: begin
        w_new.idx0 = '0;
        w_new.idx1 = '0;
      end
      default: begin
        w_new.idx0 = index0_t1;
        w_new.idx1 = index1_t1;
      end
    endcase
  end

  gc_pair_fifo #(
    .T     (rec_pair_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_new),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Slot selection: slot1 is presented once slot0 has gone, or straight away
  // when the entry never had a slot0 (label cycle with only data1 valid).
  assign w_valid    = !w_empty;
  assign w_sel1     = r_sub || !w_head.v0;
  assign w_cur_last = w_sel1 || !w_head.v1;
  assign w_xfer     = w_valid && out_ready;
  assign w_pop      = w_xfer && w_cur_last;
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sub      <= 1'b0;
      r_cc_seen  <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_xfer) r_sub <= !w_cur_last;
      if (cid == CC_ID) r_cc_seen <= 1'b1;
      if (w_push_req && !w_push) r_overflow <= 1'b1;
      if (r_cc_seen && w_empty) r_done <= 1'b1;
    end
  end

  // Record fields are forced to zero while nothing is buffered, so an
  // asynchronous reset (which empties the FIFO) clears them at once.
  assign out_valid = w_valid;
  assign out_type  = w_valid ? w_head.rtype : 2'b00;
  assign out_cid   = w_valid ? w_head.cid : '0;
  assign out_index = !w_valid ? '0 : (w_sel1 ? w_head.idx1 : w_head.idx0);
  assign out_data  = !w_valid ? '0 : (w_sel1 ? w_head.data1 : w_head.data0);
  assign out_last  = w_valid && r_cc_seen && (w_count == CW'(1)) && w_cur_last;
  assign overflow  = r_overflow;
  assign done      = r_done;

endmodule

// File: tb/tb_gc_output_collector.sv
// tb/tb_gc_output_collector.sv - self-checking bench for gc_output_collector
module tb_gc_output_collector;

  localparam int S     = 10;
  localparam int K     = 128;
  localparam int CC    = 5;
  localparam int DEPTH = 4;

  localparam logic [K-1:0] DA5 = {16{8'hA5}};
  localparam logic [K-1:0] D5A = {16{8'h5A}};
  localparam logic [K-1:0] DD0 = {4{32'hD0D0_0000}};
  localparam logic [K-1:0] DD1 = {4{32'hD1D1_1111}};

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   tag_t1;
  logic [S-1:0] cid;
  logic [S-1:0] index0_t1;
  logic [S-1:0] index1_t1;
  logic [K-1:0] data0_t1;
  logic [K-1:0] data1_t1;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_type;
  logic [S-1:0] out_cid;
  logic [S-1:0] out_index;
  logic [K-1:0] out_data;
  logic         out_last;
  logic         overflow;
  logic         done;

  always #5 clk = ~clk;

  gc_output_collector #(.S(S), .K(K), .CC(CC), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .tag_t1    (tag_t1),
    .cid       (cid),
    .index0_t1 (index0_t1),
    .index1_t1 (index1_t1),
    .data0_t1  (data0_t1),
    .data1_t1  (data1_t1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_type  (out_type),
    .out_cid   (out_cid),
    .out_index (out_index),
    .out_data  (out_data),
    .out_last  (out_last),
    .overflow  (overflow),
    .done      (done)
  );

  typedef struct {
    logic [1:0]   rtype;
    logic [S-1:0] cid;
    logic [S-1:0] idx;
    logic [K-1:0] data;
    logic         last;
  } exp_rec_t;

  typedef struct {
    logic [2:0]   tag;
    logic [S-1:0] cid;
    logic [S-1:0] i0;
    logic [S-1:0] i1;
    logic [K-1:0] d0;
    logic [K-1:0] d1;
    int           n;
    exp_rec_t     r0;
    exp_rec_t     r1;
  } vec_t;

  exp_rec_t q[$];
  exp_rec_t m_e;
  vec_t     vecs[8];
  int       n_checks = 0;
  int       n_fail = 0;

  task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_rec_t er(input logic [1:0] t, input logic [S-1:0] c,
                                  input logic [S-1:0] i, input logic [K-1:0] d);
    exp_rec_t r;
    r.rtype = t; r.cid = c; r.idx = i; r.data = d; r.last = 1'b0;
    return r;
  endfunction

  function automatic vec_t mk(input logic [2:0] tg, input logic [S-1:0] c,
                              input logic [S-1:0] a, input logic [S-1:0] b,
                              input logic [K-1:0] x, input logic [K-1:0] y,
                              input int n, input exp_rec_t r0, input exp_rec_t r1);
    vec_t v;
    v.tag = tg; v.cid = c; v.i0 = a; v.i1 = b; v.d0 = x; v.d1 = y;
    v.n = n; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic drive(input logic [2:0] tg, input logic [S-1:0] c, input logic [S-1:0] a,
                       input logic [S-1:0] b, input logic [K-1:0] x, input logic [K-1:0] y);
    tag_t1 = tg; cid = c; index0_t1 = a; index1_t1 = b; data0_t1 = x; data1_t1 = y;
  endtask

  task automatic idle();
    drive(3'b000, '0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = budget;
    while (q.size() > 0 && b > 0) begin
      @(posedge clk);
      b--;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d records still expected after %0d cycles", q.size(), budget);
      q.delete();
    end
  endtask

  // Scoreboard: every accepted record is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_record: got type %0d idx %0d data %h, expected none",
                 out_type, out_index, out_data);
      end else begin
        m_e = q.pop_front();
        chk("rec_type", K'(out_type), K'(m_e.rtype));
        chk("rec_cid", K'(out_cid), K'(m_e.cid));
        chk("rec_index", K'(out_index), K'(m_e.idx));
        chk("rec_data", out_data, m_e.data);
        chk("rec_last", K'(out_last), K'(m_e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]   snap_type;
    logic [S-1:0] snap_idx;
    logic [K-1:0] snap_data;
    logic [K-1:0] tmp0;
    logic [K-1:0] tmp1;
    exp_rec_t     r;

    vecs[0] = mk(3'b001, 10'd1, 10'h3ff, 10'h3ff, DA5, D5A, 2,
                 er(2'd1, 10'd1, 10'd0, DA5), er(2'd1, 10'd1, 10'd1, D5A));
    vecs[1] = mk(3'b101, 10'd0, 10'd7, 10'd9, DD0, DD1, 1,
                 er(2'd0, 10'd0, 10'd7, DD0), er(2'd0, 10'd0, 10'd0, '0));
    vecs[2] = mk(3'b110, 10'd2, 10'd3, 10'd12, DD0, DD1, 1,
                 er(2'd0, 10'd2, 10'd12, DD1), er(2'd0, 10'd0, 10'd0, '0));
    vecs[3] = mk(3'b111, 10'd3, 10'd100, 10'd200, DA5, DD1, 2,
                 er(2'd0, 10'd3, 10'd100, DA5), er(2'd0, 10'd3, 10'd200, DD1));
    vecs[4] = mk(3'b010, 10'd4, 10'd5, 10'd6, DD1, DD0, 2,
                 er(2'd2, 10'd4, 10'd5, DD1), er(2'd2, 10'd4, 10'd6, DD0));
    vecs[5] = mk(3'b011, 10'd1, 10'd8, 10'd9, D5A, DA5, 1,
                 er(2'd3, 10'd1, 10'd0, D5A), er(2'd0, 10'd0, 10'd0, '0));
    vecs[6] = mk(3'b000, 10'd2, 10'd1, 10'd2, DA5, DA5, 0,
                 er(2'd0, 10'd0, 10'd0, '0), er(2'd0, 10'd0, 10'd0, '0));
    vecs[7] = mk(3'b100, 10'd3, 10'd1, 10'd2, DA5, DA5, 0,
                 er(2'd0, 10'd0, 10'd0, '0), er(2'd0, 10'd0, 10'd0, '0));

    rst = 1'b0;
    out_ready = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk("reset_out_valid", K'(out_valid), '0);
    chk("reset_out_last", K'(out_last), '0);
    chk("reset_overflow", K'(overflow), '0);
    chk("reset_done", K'(done), '0);
    chk("reset_out_type", K'(out_type), '0);
    chk("reset_out_cid", K'(out_cid), '0);
    chk("reset_out_index", K'(out_index), '0);
    chk("reset_out_data", out_data, '0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Table-driven single cycles, each followed by idles long enough to drain.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 drive(vecs[i].tag, vecs[i].cid, vecs[i].i0, vecs[i].i1, vecs[i].d0, vecs[i].d1);
      if (vecs[i].n >= 1) q.push_back(vecs[i].r0);
      if (vecs[i].n >= 2) q.push_back(vecs[i].r1);
      @(negedge clk);
      chk("valid_same_cycle", K'(out_valid), '0);
      @(posedge clk);
      #1 idle();
      @(negedge clk);
      chk("valid_next_cycle", K'(out_valid), K'(vecs[i].n != 0));
      @(posedge clk);
      #1 idle();
    end
    wait_drain(20);
    @(negedge clk);
    chk("no_overflow_table", K'(overflow), '0);
    chk("no_done_table", K'(done), '0);

    // Three TABLE cycles buffered while stalled, then released.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      tmp0 = {4{32'hC0DE_0000 + 32'(k)}};
      tmp1 = {4{32'hBEEF_0000 + 32'(k)}};
      #1 drive(3'b010, S'(k), S'(20 + 2 * k), S'(21 + 2 * k), tmp0, tmp1);
      q.push_back(er(2'd2, S'(k), S'(20 + 2 * k), tmp0));
      q.push_back(er(2'd2, S'(k), S'(21 + 2 * k), tmp1));
    end
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    snap_type = out_type;
    snap_idx  = out_index;
    snap_data = out_data;
    chk("stall_head_index", K'(out_index), K'(20));
    repeat (3) begin
      @(negedge clk);
      chk("stall_type_stable", K'(out_type), K'(snap_type));
      chk("stall_index_stable", K'(out_index), K'(snap_idx));
      chk("stall_data_stable", out_data, snap_data);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain(20);

    // Overflow: five MASK cycles into a 4-deep FIFO with the consumer stalled.
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      tmp0 = {4{32'hAA00_0000 + 32'(k)}};
      #1 drive(3'b011, S'(k), 10'd33, 10'd44, tmp0, DA5);
      if (k < DEPTH) q.push_back(er(2'd3, S'(k), 10'd0, tmp0));
      @(negedge clk);
      chk("overflow_before_drop", K'(overflow), '0);
    end
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    chk("overflow_after_drop", K'(overflow), K'(1));
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain(20);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("overflow_drained_empty", K'(out_valid), '0);
    chk("overflow_sticky", K'(overflow), K'(1));

    // End of run: two label cycles then cid==CC; only the 4th record is last.
    do_reset();
    out_ready = 1'b0;
    @(posedge clk);
    #1 drive(3'b111, 10'd0, 10'd1, 10'd2, DA5, D5A);
    q.push_back(er(2'd0, 10'd0, 10'd1, DA5));
    q.push_back(er(2'd0, 10'd0, 10'd2, D5A));
    @(posedge clk);
    #1 drive(3'b111, 10'd1, 10'd3, 10'd4, DD0, DD1);
    q.push_back(er(2'd0, 10'd1, 10'd3, DD0));
    r = er(2'd0, 10'd1, 10'd4, DD1);
    r.last = 1'b1;
    q.push_back(r);
    @(posedge clk);
    #1 drive(3'b001, S'(CC), 10'd0, 10'd0, DA5, DA5);
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    chk("cc_last_two_entries", K'(out_last), '0);
    chk("cc_done_pending", K'(done), '0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain(20);
    @(negedge clk);
    chk("cc_done_not_yet", K'(done), '0);
    @(negedge clk);
    chk("cc_done_after_drain", K'(done), K'(1));
    chk("cc_empty_after_drain", K'(out_valid), '0);

    // Empty run: CC reached with nothing pushed.
    do_reset();
    @(posedge clk);
    #1 drive(3'b000, S'(CC), 10'd0, 10'd0, '0, '0);
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    chk("empty_run_done_early", K'(done), '0);
    @(negedge clk);
    chk("empty_run_done", K'(done), K'(1));
    chk("empty_run_no_last", K'(out_last), '0);
    chk("empty_run_no_valid", K'(out_valid), '0);

    // Reset with three entries buffered discards them immediately.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 drive(3'b001, S'(k), 10'd0, 10'd0, DD0, DD1);
    end
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    chk("pre_reset_valid", K'(out_valid), K'(1));
    #2 rst = 1'b0;
    #1;
    chk("async_reset_valid", K'(out_valid), '0);
    chk("async_reset_data", out_data, '0);
    chk("async_reset_type", K'(out_type), '0);
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("no_stale_records", K'(out_valid), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
